// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch controller and instruction memory.
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC/fetch controller: issues imem requests, handles redirects, flushes and decode stalls.
// Define MISALIGN_TRAP_EN to trap misaligned redirect targets to TRAP_VEC instead of masking.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             PCSrc,
  input  logic                   redirect_valid,
  input  logic [31:0]            PCTarget,
  input  logic [31:0]            ALUResult,
  input  logic                   stall,
  pc_fetch_ctrl_if.master        imem,
  output logic [31:0]            InstrF,
  output logic [31:0]            PCF,
  output logic                   InstrValidF,
  output logic                   FlushD,
  output logic                   FlushE,
  output logic                   misalign_trap,
  output logic [31:0]            bad_addr
);

  typedef enum logic [1:0] {StIdle, StReq, StDiscard, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcf_q, pcf_d;
  logic        valid_q, valid_d;

  logic        taken;
  logic [31:0] raw_target;
  logic [31:0] target;

  assign taken      = redirect_valid && ((PCSrc == 2'b01) || (PCSrc == 2'b10));
  assign raw_target = (PCSrc == 2'b01) ? PCTarget : ALUResult;

`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
  logic        trap_q;
  logic [31:0] bad_q;

  assign misaligned = taken && (raw_target[1:0] != 2'b00);
  assign target     = misaligned ? TRAP_VEC : raw_target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_q <= 1'b0;
      bad_q  <= 32'h0;
    end else begin
      trap_q <= misaligned;
      if (misaligned) begin
        bad_q <= raw_target;
      end
    end
  end

  assign misalign_trap = trap_q;
  assign bad_addr      = bad_q;
`else
  logic unused_trap_vec;

  assign unused_trap_vec = ^TRAP_VEC;
  assign target          = raw_target & ~32'h3;
  assign misalign_trap   = 1'b0;
  assign bad_addr        = 32'h0;
`endif

  assign FlushD = taken;
  assign FlushE = taken;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    instr_d   = instr_q;
    pcf_d     = pcf_q;
    valid_d   = valid_q;
    case (state_q)
      StIdle: begin
        // Acks seen here belong to an abandoned request and are ignored.
        valid_d = 1'b0;
        if (taken) begin
          pc_d = target;
        end else if (!stall) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (imem.imem_ack) begin
          if (taken) begin
            valid_d = 1'b0;
            pc_d    = target;
            state_d = StIdle;
          end else begin
            instr_d = imem.imem_rdata;
            pcf_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = stall ? StHold : StReq;
          end
        end else if (taken) begin
          pending_d = target;
          valid_d   = 1'b0;
          state_d   = StDiscard;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      StDiscard: begin
        // Request stays on the bus until acked; newest redirect target wins.
        valid_d = 1'b0;
        if (imem.imem_ack) begin
          pc_d    = taken ? target : pending_q;
          state_d = StIdle;
        end else if (taken) begin
          pending_d = target;
        end
      end
      StHold: begin
        if (taken) begin
          valid_d = 1'b0;
          pc_d    = target;
          state_d = StIdle;
        end else if (!stall) begin
          valid_d = 1'b0;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      pending_q <= 32'h0;
      instr_q   <= 32'h0;
      pcf_q     <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      instr_q   <= instr_d;
      pcf_q     <= pcf_d;
      valid_q   <= valid_d;
    end
  end

  assign imem.imem_req  = (state_q == StReq) || (state_q == StDiscard);
  assign imem.imem_addr = pc_q;
  assign InstrF         = instr_q;
  assign PCF            = pcf_q;
  assign InstrValidF    = valid_q;

endmodule
